// File: rtl/uart_parity_odd_tx_if.sv
// Host-side word handshake for the odd-parity UART transmitter.
// The host drives the word and error-injection flag; the transmitter answers with ready.
interface uart_parity_odd_tx_if #(
    parameter int DATA_W = 4
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_perr;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_perr,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_perr,
        output tx_ready
    );
endinterface

// File: rtl/uart_parity_odd_tx.sv
// Odd-parity serial transmitter: start(0), DATA_W bits LSB first, parity, stop(1).
// Line idles high; frames may run back-to-back when a word is accepted in the last stop cycle.
module uart_parity_odd_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_parity_odd_tx_if.slave     bus,
    output logic                    busy,
    output logic                    tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    // Cycle before the last one; only meaningful when a bit spans several clocks.
    localparam logic [CW-1:0] CLK_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic              parity;
    logic              ready;
    logic              accept;

    assign bus.tx_ready = ready;
    assign accept       = bus.tx_valid && ready;
    assign shift_nx     = shift >> 1;

    // NOTE: all state, including the shift register, is updated with non-blocking
    // assignments and cleared on reset so the line is never X after the first reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (accept) begin
                        shift  <= bus.tx_data;
                        parity <= ~^bus.tx_data ^ bus.tx_perr;
                        state  <= START;
                        tx     <= 1'b0;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end else begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end

                default: begin
                    if (clk_cnt != CLK_LAST) begin
                        clk_cnt <= clk_cnt + 1'b1;
                        // Ready rises one clock ahead so it is high exactly in the final stop cycle.
                        if (state == STOP && CLKS_PER_BIT > 1 && clk_cnt == CLK_PRE)
                            ready <= 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        case (state)
                            START: begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                tx      <= shift[0];
                            end
                            DATA: begin
                                if (bit_cnt == BIT_LAST) begin
                                    state   <= PARITY;
                                    bit_cnt <= '0;
                                    tx      <= parity;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    shift   <= shift_nx;
                                    tx      <= shift_nx[0];
                                end
                            end
                            PARITY: begin
                                state <= STOP;
                                tx    <= 1'b1;
                                ready <= (CLKS_PER_BIT == 1);
                            end
                            STOP: begin
                                if (accept) begin
                                    // Back-to-back: straight into the next start bit, busy stays high.
                                    shift  <= bus.tx_data;
                                    parity <= ~^bus.tx_data ^ bus.tx_perr;
                                    state  <= START;
                                    tx     <= 1'b0;
                                    ready  <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                    tx    <= 1'b1;
                                    busy  <= 1'b0;
                                    ready <= 1'b1;
                                end
                            end
                            default: begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                                ready <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_parity_odd_tx.sv
// Bench for uart_parity_odd_tx: two instances (1 and 3 clocks per bit), directed words,
// expected frames queued at handshake and checked by a line-receiver monitor per instance.
module tb_uart_parity_odd_tx;

    typedef struct {
        logic [3:0] data;
        logic       par;
        logic       err;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic busy1, busy3;
    logic tx1, tx3;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q0[$];
    exp_t q1[$];

    uart_parity_odd_tx_if #(.DATA_W(4)) bus1 ();
    uart_parity_odd_tx_if #(.DATA_W(4)) bus3 ();

    uart_parity_odd_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave),
        .busy  (busy1),
        .tx    (tx1)
    );

    uart_parity_odd_tx #(.DATA_W(4), .CLKS_PER_BIT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave),
        .busy  (busy3),
        .tx    (tx3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel == 0) ? tx1 : tx3;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus1.tx_ready : bus3.tx_ready;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 0) ? busy1 : busy3;
    endfunction

    // Line receiver: samples every clock of every bit, decodes the frame and scores it.
    task automatic monitor(input int sel);
        int         cpb;
        int         start;
        logic [6:0] bits;
        logic       hold_ok;
        logic       aborted;
        logic [3:0] data;
        logic       par;
        logic       err;
        exp_t       e;
        cpb = (sel == 0) ? 1 : 3;
        forever begin
            do @(negedge clk); while (!(line(sel) === 1'b0 && reset === 1'b1));
            start   = cyc;
            aborted = 1'b0;
            hold_ok = 1'b1;
            bits    = '0;
            for (int b = 0; b < 7 && !aborted; b++) begin
                for (int s = 0; s < cpb; s++) begin
                    if (!(b == 0 && s == 0)) @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s == 0) bits[b] = line(sel);
                    else if (line(sel) !== bits[b]) hold_ok = 1'b0;
                end
            end
            if (!aborted) begin
                data = bits[4:1];
                par  = bits[5];
                err  = ~(^{data, par});
                if ((sel == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("unexpected_frame%0d", sel), 32'(data), 32'hdead);
                end else begin
                    e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("data%0d", sel),       32'(data),    32'(e.data));
                    check($sformatf("parity%0d", sel),     32'(par),     32'(e.par));
                    check($sformatf("rx_error%0d", sel),   32'(err),     32'(e.err));
                    check($sformatf("start_cycle%0d", sel), 32'(start),  32'(e.start));
                    check($sformatf("stop%0d", sel),       32'(bits[6]), 32'd1);
                    check($sformatf("bit_hold%0d", sel),   32'(hold_ok), 32'd1);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Present a word; expected frame is queued at the handshake edge.
    task automatic send(input int sel, input logic [3:0] d, input logic pe,
                        input logic par, input logic err, input logic keep);
        exp_t e;
        int   n;
        if (sel == 0) begin
            bus1.tx_valid = 1'b1; bus1.tx_data = d; bus1.tx_perr = pe;
        end else begin
            bus3.tx_valid = 1'b1; bus3.tx_data = d; bus3.tx_perr = pe;
        end
        n = 0;
        while (rdy(sel) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_wait%0d", sel), 32'(n < 100), 32'd1);
        e.data  = d;
        e.par   = par;
        e.err   = err;
        e.start = cyc + 1;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        if (!keep) begin
            if (sel == 0) bus1.tx_valid = 1'b0; else bus3.tx_valid = 1'b0;
        end
    endtask

    // Called right after a handshake: ready low for the frame, high only in the final stop cycle.
    task automatic ready_trace(input int sel, input int cpb);
        for (int i = 0; i < 7 * cpb; i++) begin
            check($sformatf("ready_in_frame%0d_c%0d", sel, i), 32'(rdy(sel)), 32'(i == 7 * cpb - 1));
            check($sformatf("busy_in_frame%0d_c%0d", sel, i),  32'(bsy(sel)), 32'd1);
            @(negedge clk);
        end
        check($sformatf("idle_busy%0d", sel),  32'(bsy(sel)),  32'd0);
        check($sformatf("idle_ready%0d", sel), 32'(rdy(sel)),  32'd1);
        check($sformatf("idle_tx%0d", sel),    32'(line(sel)), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.tx_perr = 1'b0;
        bus3.tx_valid = 1'b0; bus3.tx_data = '0; bus3.tx_perr = 1'b0;

        // Reset held three cycles, then released with no traffic.
        repeat (3) @(negedge clk);
        check("rst_tx1",    32'(tx1),           32'd1);
        check("rst_ready1", 32'(bus1.tx_ready), 32'd1);
        check("rst_busy1",  32'(busy1),         32'd0);
        check("rst_tx3",    32'(tx3),           32'd1);
        check("rst_ready3", 32'(bus3.tx_ready), 32'd1);
        check("rst_busy3",  32'(busy3),         32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("quiet_tx1", 32'(tx1), 32'd1);
            check("quiet_tx3", 32'(tx3), 32'd1);
        end

        // 1011: line 0,1,1,0,1,0,1
        send(0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        ready_trace(0, 1);

        // Parity corner words.
        send(0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Valid held high across two words: second start directly after first stop.
        send(0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Error injection: even parity on the line.
        send(0, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Reset during data bit 2 aborts the frame.
        send(0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx1",    32'(tx1),           32'd1);
        check("abort_busy1",  32'(busy1),         32'd0);
        check("abort_ready1", 32'(bus1.tx_ready), 32'd1);
        if (q0.size() > 0) void'(q0.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Three clocks per bit.
        send(1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        ready_trace(1, 3);
        send(1, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        check("pending_frames0", 32'(q0.size()), 32'd0);
        check("pending_frames1", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
